// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO port bundle: UART receiver strobes in, head entry, status and interrupts out.
// slave = FIFO side, master = receiver/bus side.
interface uart_rx_fifo_if #(
    parameter int DEPTH              = 16,
    parameter int AW                 = $clog2(DEPTH),
    parameter int UART_DATA_SIZE     = 8,
    parameter int UART_BAUD_DIV_SIZE = 16
);
    logic [UART_DATA_SIZE-1:0]     rx_data_i;
    logic                          rx_valid_i;
    logic                          rx_frame_err_i;
    logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i;
    logic                          rd_req_i;
    logic [AW:0]                   thresh_i;
    logic                          overrun_clr_i;
    logic [UART_DATA_SIZE-1:0]     rd_data_o;
    logic                          rd_frame_err_o;
    logic                          empty_o;
    logic                          full_o;
    logic [AW:0]                   level_o;
    logic                          overrun_o;
    logic                          thresh_irq_o;
    logic                          timeout_irq_o;

    modport slave (
        input  rx_data_i, rx_valid_i, rx_frame_err_i, baud_div_i, rd_req_i, thresh_i, overrun_clr_i,
        output rd_data_o, rd_frame_err_o, empty_o, full_o, level_o, overrun_o, thresh_irq_o, timeout_irq_o
    );

    modport master (
        output rx_data_i, rx_valid_i, rx_frame_err_i, baud_div_i, rd_req_i, thresh_i, overrun_clr_i,
        input  rd_data_o, rd_frame_err_o, empty_o, full_o, level_o, overrun_o, thresh_irq_o, timeout_irq_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FWFT FIFO with level-threshold irq, sticky overrun and optional char-timeout irq (UART_RX_TIMEOUT_EN).
// Latency: a push is visible on the head/status outputs right after its clock edge; head is combinational.
// Backpressure: none toward the receiver -- a byte arriving while full (and not popped) is dropped and flags overrun.
module uart_rx_fifo #(
    parameter int DEPTH              = 16,
    parameter int AW                 = $clog2(DEPTH),
    parameter int UART_DATA_SIZE     = 8,
    parameter int UART_BAUD_DIV_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_rx_fifo_if.slave    bus
);
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [UART_DATA_SIZE:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, level;
    logic        empty, full, wr, do_push, do_pop, ovr_set, overrun;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign wr      = bus.rx_valid_i | bus.rx_frame_err_i;
    assign do_pop  = bus.rd_req_i & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = wr & (~full | do_pop);
    assign ovr_set = wr & full & ~do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (ovr_set)
                overrun <= 1'b1;
            else if (bus.overrun_clr_i)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= {bus.rx_frame_err_i, bus.rx_data_i};
    end

    assign bus.rd_data_o      = empty ? '0 : mem[rd_ptr[AW-1:0]][UART_DATA_SIZE-1:0];
    assign bus.rd_frame_err_o = empty ? 1'b0 : mem[rd_ptr[AW-1:0]][UART_DATA_SIZE];
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.level_o        = level;
    assign bus.overrun_o      = overrun;
    assign bus.thresh_irq_o   = (bus.thresh_i != '0) && (level >= bus.thresh_i);

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [UART_BAUD_DIV_SIZE:0] ONE = 1;
    localparam logic [5:0] TMO_BITS = 6'd40;

    logic [UART_BAUD_DIV_SIZE-1:0] presc;
    logic [UART_BAUD_DIV_SIZE:0]   presc_inc;
    logic [5:0]                    bit_cnt;
    logic                          tick, tmo_irq, activity;

    assign presc_inc = {1'b0, presc} + ONE;
    // ">=" rather than "==" keeps a divisor of 0 or a mid-count divisor change from stalling the tick.
    assign tick      = presc_inc >= {1'b0, bus.baud_div_i};
    assign activity  = do_push | do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            bit_cnt <= '0;
            tmo_irq <= 1'b0;
        end else begin
            if (activity || empty) begin
                presc   <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                presc <= '0;
                if (bit_cnt != TMO_BITS) bit_cnt <= bit_cnt + 1'b1;
            end else begin
                presc <= presc_inc[UART_BAUD_DIV_SIZE-1:0];
            end

            if (activity)
                tmo_irq <= 1'b0;
            else if (!empty && tick && bit_cnt == TMO_BITS - 6'd1)
                tmo_irq <= 1'b1;
        end
    end

    assign bus.timeout_irq_o = tmo_irq;
`else
    logic unused_baud;
    assign unused_baud       = ^bus.baud_div_i;
    assign bus.timeout_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: queue scoreboard of {frame_err,data} entries plus a small status model.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(16), .UART_DATA_SIZE(8), .UART_BAUD_DIV_SIZE(16)) bus ();

    uart_rx_fifo #(.DEPTH(16), .UART_DATA_SIZE(8), .UART_BAUD_DIV_SIZE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] q[$];
    logic       m_ov = 1'b0;
    int         m_thr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        int lvl;
        lvl = q.size();
        chk({tag, ":level"}, 32'(bus.level_o), 32'(lvl));
        chk({tag, ":empty"}, 32'(bus.empty_o), 32'(lvl == 0));
        chk({tag, ":full"}, 32'(bus.full_o), 32'(lvl == 16));
        chk({tag, ":overrun"}, 32'(bus.overrun_o), 32'(m_ov));
        chk({tag, ":thresh_irq"}, 32'(bus.thresh_irq_o), 32'((m_thr != 0) && (lvl >= m_thr)));
        if (lvl == 0)
            chk({tag, ":head_empty"}, {23'd0, bus.rd_frame_err_o, bus.rd_data_o}, 32'd0);
        else
            chk({tag, ":head"}, {23'd0, bus.rd_frame_err_o, bus.rd_data_o}, {23'd0, q[0]});
    endtask

    // One clock: drive strobes, update the model from pre-edge state, then check post-edge outputs.
    task automatic cyc(input string tag, input logic vld, input logic ferr, input logic [7:0] d,
                       input logic pop, input logic clr);
        logic pop_ok, push_ok, wr;
        logic [8:0] exp;
        bus.rx_valid_i     = vld;
        bus.rx_frame_err_i = ferr;
        bus.rx_data_i      = d;
        bus.rd_req_i       = pop;
        bus.overrun_clr_i  = clr;
        wr      = vld | ferr;
        pop_ok  = pop && (q.size() != 0);
        push_ok = wr && ((q.size() < 16) || pop_ok);
        if (pop_ok) begin
            exp = q.pop_front();
            chk({tag, ":pop_data"}, {23'd0, bus.rd_frame_err_o, bus.rd_data_o}, {23'd0, exp});
        end
        if (push_ok) q.push_back({ferr, d});
        if (wr && !push_ok) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        @(posedge clk); #1;
        bus.rx_valid_i     = 1'b0;
        bus.rx_frame_err_i = 1'b0;
        bus.rd_req_i       = 1'b0;
        bus.overrun_clr_i  = 1'b0;
        chk_state(tag);
    endtask

    task automatic push(input string tag, input logic [7:0] d);
        cyc(tag, 1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        cyc(tag, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int k;
        logic seen;
        bus.rx_data_i      = '0;
        bus.rx_valid_i     = 1'b0;
        bus.rx_frame_err_i = 1'b0;
        bus.baud_div_i     = 16'd10;
        bus.rd_req_i       = 1'b0;
        bus.thresh_i       = '0;
        bus.overrun_clr_i  = 1'b0;
        #23;
        chk_state("reset");
        chk("reset:timeout", 32'(bus.timeout_irq_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ordering
        push("basic_push", 8'hA5);
        push("basic_push", 8'h3C);
        pop("basic_pop");
        pop("basic_pop");

        // Frame-error entry then a clean byte
        cyc("ferr_push", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        push("ferr_clean", 8'h12);
        pop("ferr_pop");
        pop("ferr_pop");

        // Pop when empty is ignored
        pop("underflow");

        // Fill, overrun, drain, clear
        for (int i = 0; i < 16; i++) push("fill", 8'(i));
        push("overrun_drop", 8'hFF);
        for (int i = 0; i < 16; i++) pop("drain");
        cyc("ovr_clr", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Set and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) push("fill2", 8'(8'h20 + i));
        cyc("ovr_set_clr", 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        cyc("ovr_clr2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Push together with pop while full: level stays 16, 0x77 comes out last
        cyc("full_push_pop", 1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) pop("drain2");
        chk("last_is_77", 32'(bus.rd_data_o), 32'h77);
        pop("drain2_last");

        // Push together with pop while empty: no bypass
        cyc("empty_push_pop", 1'b1, 1'b0, 8'h44, 1'b1, 1'b0);
        pop("drain3");

        // Threshold interrupt
        bus.thresh_i = 5'd4;
        m_thr = 4;
        for (int i = 0; i < 4; i++) push("thr_push", 8'(8'h60 + i));
        pop("thr_pop");
        for (int i = 0; i < 3; i++) pop("thr_drain");
        bus.thresh_i = 5'd0;
        m_thr = 0;
        for (int i = 0; i < 5; i++) push("thr0_push", 8'(8'h70 + i));
        for (int i = 0; i < 5; i++) pop("thr0_drain");

        // Character timeout
        push("tmo_push", 8'h81);
        seen = 1'b0;
        k = 0;
        for (int i = 1; i <= 500 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.timeout_irq_o) begin
                seen = 1'b1;
                k = i;
            end
        end
`ifdef UART_RX_TIMEOUT_EN
        chk("tmo_seen", 32'(seen), 32'd1);
        chk("tmo_latency_in_390_410", 32'((k >= 390) && (k <= 410)), 32'd1);
        pop("tmo_pop");
        chk("tmo_cleared", 32'(bus.timeout_irq_o), 32'd0);
`else
        chk("tmo_disabled", 32'(seen), 32'd0);
        pop("tmo_pop");
`endif

        // Asynchronous reset mid-operation
        push("arst_push", 8'h91);
        push("arst_push", 8'h92);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ov = 1'b0;
        chk_state("arst");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_state("arst_release");
        push("post_arst", 8'hC3);
        pop("post_arst_pop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
